// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: address map constants and the
// sprite-DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] PPU_BASE    = 16'h2000;
  localparam logic [15:0] APU_IO_BASE = 16'h4000;
  localparam logic [15:0] CART_BASE   = 16'h4020;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and decoder-side bus bundle around the sprite DMA.
// slave is the DMA view, master the surrounding system.
interface oam_dma_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_write;
  logic [7:0]  cpu_din;
  logic        cpu_hold;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_write;
  logic [7:0]  bus_din;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_write, bus_din,
    output cpu_din, cpu_hold,
    output bus_addr, bus_dout, bus_write
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_write, bus_din,
    input  cpu_din, cpu_hold,
    input  bus_addr, bus_dout, bus_write
  );

endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a $4014 write stalls the cpu and copies one
// 256-byte page into PPU OAM, read/write alternating.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  =
    nes_bus_pkg::DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR =
    nes_bus_pkg::OAM_DATA_ADDR_DEF,
  parameter bit          ALIGN_ODD     = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.slave  bus,
  output logic      dma_active
);

  import nes_bus_pkg::*;

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       odd_q;
  logic       hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      odd_q   <= ~odd_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    page_d        = page_q;
    idx_d         = idx_q;
    data_d        = data_q;
    hold          = 1'b0;
    bus.bus_addr  = bus.cpu_addr;
    bus.bus_dout  = bus.cpu_dout;
    bus.bus_write = bus.cpu_write;
    unique case (state_q)
      IDLE: begin
        // the trigger write itself still reaches the bus
        if (bus.cpu_write &&
            bus.cpu_addr == DMA_REG_ADDR) begin
          page_d  = bus.cpu_dout;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        hold          = 1'b1;
        bus.bus_write = 1'b0;
        state_d = (ALIGN_ODD && odd_q) ? ALIGN : READ;
      end
      ALIGN: begin
        hold          = 1'b1;
        bus.bus_write = 1'b0;
        state_d       = READ;
      end
      READ: begin
        hold          = 1'b1;
        bus.bus_addr  = {page_q, idx_q};
        bus.bus_write = 1'b0;
        data_d        = bus.bus_din;
        state_d       = WRITE;
      end
      WRITE: begin
        hold          = 1'b1;
        bus.bus_addr  = OAM_DATA_ADDR;
        bus.bus_dout  = data_q;
        bus.bus_write = 1'b1;
        if (idx_q == 8'hFF) begin
          idx_d   = 8'h00;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_din  = bus.bus_din;
  assign bus.cpu_hold = hold;
  assign dma_active   = hold;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite-DMA engine on the CPU bus, between the cpu core and the memory/PPU address decoder.
- When the cpu writes a page number to $4014, the block stalls the cpu through `cpu_hold`, which drives the cpu's hold input.
- While the cpu is stalled, it copies 256 bytes from {page, 8'h00..8'hFF} to the PPU OAM data port ($2004), alternating read and write cycles.
- When idle, it is a transparent pass-through of the cpu bus.

Parameters:
- DMA_REG_ADDR, 16'h4014, cpu write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address written once per byte.
- ALIGN_ODD, 1, when 1 insert one alignment cycle if the halt cycle falls on an odd clock.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- cpu_addr  in  16  address from the cpu core.
- cpu_dout  in  8  write data from the cpu core.
- cpu_write  in  1  write strobe from the cpu core.
- cpu_din  out  8  read data to the cpu core (always equals bus_din).
- cpu_hold  out  1  stall request to the cpu core; high while DMA owns the bus.
- bus_addr  out  16  address to memory/decoder.
- bus_dout  out  8  write data to memory/decoder.
- bus_write  out  1  write strobe to memory/decoder.
- bus_din  in  8  read data from memory/decoder; combinationally valid in the same cycle as bus_addr.
- dma_active  out  1  high from the HALT state through the last WRITE cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, page=0, idx=0, data=0, odd=0.
  - cpu_hold=0, dma_active=0.
  - bus_* mirror cpu_* combinationally.
- Parity flop `odd` toggles every clk edge, in every state.
- Trigger: in IDLE, cpu_write=1 && cpu_addr==DMA_REG_ADDR at a rising edge:
  - page<=cpu_dout, idx<=0, state<=HALT.
  - The trigger write itself passes through to the bus unchanged.
- IDLE outputs: bus_addr=cpu_addr, bus_dout=cpu_dout, bus_write=cpu_write, cpu_hold=0.
- HALT (1 cycle):
  - cpu_hold=1, bus_write=0, bus_addr=cpu_addr.
  - Next state: ALIGN if ALIGN_ODD && odd==1, otherwise READ.
- ALIGN (1 cycle): cpu_hold=1, bus_write=0; next state READ.
- READ:
  - bus_addr={page,idx}, bus_write=0, cpu_hold=1.
  - data<=bus_din at the edge; next state WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_dout=data, bus_write=1, cpu_hold=1.
  - If idx==8'hFF: state<=IDLE, idx<=0.
  - Else: idx<=idx+1, state<=READ.
- idx is 8 bits and wraps; page is never incremented, so no page crossing.
- Stall length, counted from the first cycle after the trigger: 513 cycles (HALT + 512), or 514 with ALIGN.
- Exactly 256 bus writes to OAM_DATA_ADDR per transfer.
- The cycle after the final WRITE is IDLE with cpu_hold=0.
- cpu_write or any cpu_addr value while state!=IDLE is ignored; a retrigger during a transfer has no effect.
- Reset mid-transfer: immediate return to IDLE, cpu_hold=0, no further bus writes, and the partial OAM contents are left as-is.
- dma_active equals cpu_hold.

Decomposition:
- Shared package nes_bus_pkg holds:
  - DMA_REG_ADDR and OAM_DATA_ADDR default constants;
  - the dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE};
  - bus address constants for later decoder blocks.
- No sub-module; the parity flop, FSM, counter and output mux live in one module.

Test Plan:
- Even alignment: with odd=0 at HALT, write 8'h02 to 16'h4014.
  - cpu_hold is high for exactly 513 cycles.
  - Reads cover 16'h0200..16'h02FF in order.
  - 256 writes go to 16'h2004, each carrying the preceding read byte (memory preloaded with byte=~addr[7:0]).
- Odd alignment: shift the trigger by one clock so odd=1 at HALT.
  - One extra ALIGN cycle with no bus activity.
  - Total stall is 514 cycles.
- Pass-through in IDLE: cpu_addr=16'h1234, cpu_dout=8'hA5, cpu_write=1, and bus_din=8'h3C.
  - Same cycle: bus_addr=16'h1234, bus_dout=8'hA5, bus_write=1, cpu_din=8'h3C, cpu_hold=0.
- Retrigger ignored: during byte 10, drive cpu_write=1 at 16'h4014 with 8'h07.
  - The transfer still reads page 8'h02 to completion.
  - page is unchanged.
- Reset mid-operation: assert rst low asynchronously after the 100th WRITE.
  - cpu_hold drops without waiting for a clock edge.
  - After release, no writes to 16'h2004 occur until a new trigger.
  - A new trigger with 8'h03 performs a full 256-byte transfer from 16'h0300.
- Wrap/end: at idx=8'hFF, the READ from 16'h02FF is followed by a final WRITE.
  - The next cycle is IDLE.
  - idx returns to 0.
